// File: rtl/mc_datapath_regs.sv
// Register/operand stage of the multicycle MIPS CPU: holds PC, IR, MDR, A, B, ALUOut
// and steers controller selects into ALU operands, next PC, memory and GPR write signals.
module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        EXTOp,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic        SASrc,
  input  logic [1:0]  PCSource,
  input  logic [1:0]  GPRSel,
  input  logic [1:0]  WDSel,
  input  logic        IorD,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc
);

  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] pc_next;
  logic [31:0] ext;
  logic [31:0] jump_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      if (PCWrite) pc <= pc_next;
      if (IRWrite) ir <= mem_rdata;
      // Inter-cycle registers capture every cycle; the controller decides when to use them.
      mdr     <= mem_rdata;
      a_reg   <= rf_rd1;
      b_reg   <= rf_rd2;
      alu_out <= alu_result;
    end
  end

  assign ext         = EXTOp ? {{16{ir[15]}}, ir[15:0]} : {16'b0, ir[15:0]};
  // pc already holds PC+4 when a jump executes, so the region comes from PC+4.
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};

  always_comb begin
    alu_a = 32'd0;
    case (ALUSrcA)
      2'd0:    alu_a = pc;
      2'd1:    alu_a = a_reg;
      2'd2:    alu_a = b_reg;
      default: alu_a = 32'd0;
    endcase
  end

  always_comb begin
    alu_b = 32'd0;
    case (ALUSrcB)
      2'd0:    alu_b = b_reg;
      2'd1:    alu_b = 32'd4;
      2'd2:    alu_b = ext;
      default: alu_b = {ext[29:0], 2'b00};
    endcase
  end

  assign alu_shamt = SASrc ? a_reg[4:0] : ir[10:6];

  // jr/jalr complete in ID, before A holds rs, so they take the live register read.
  always_comb begin
    pc_next = alu_result;
    case (PCSource)
      2'd0:    pc_next = alu_result;
      2'd1:    pc_next = alu_out;
      2'd2:    pc_next = jump_target;
      default: pc_next = rf_rd1;
    endcase
  end

  always_comb begin
    rf_wa = 5'd0;
    case (GPRSel)
      2'd0:    rf_wa = ir[15:11];
      2'd1:    rf_wa = ir[20:16];
      2'd2:    rf_wa = 5'd31;
      default: rf_wa = 5'd0;
    endcase
  end

  always_comb begin
    rf_wd = 32'd0;
    case (WDSel)
      2'd0:    rf_wd = alu_out;
      2'd1:    rf_wd = mdr;
      2'd2:    rf_wd = pc;
      default: rf_wd = 32'd0;
    endcase
  end

  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b_reg;
  assign rf_ra1    = ir[25:21];
  assign rf_ra2    = ir[20:16];
  assign op        = ir[31:26];
  assign funct     = ir[5:0];

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for mc_datapath_regs: drives controller selects cycle by cycle and
// compares steered outputs against hand-computed values.
module tb_mc_datapath_regs;

  logic        clk;
  logic        rst;
  logic        PCWrite, IRWrite, EXTOp, SASrc, IorD;
  logic [1:0]  ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel;
  logic [31:0] mem_rdata, alu_result, rf_rd1, rf_rd2;
  logic [31:0] mem_addr, mem_wdata, rf_wd, alu_a, alu_b, pc;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa, alu_shamt;
  logic [5:0]  op, funct;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mc_datapath_regs dut (
    .clk(clk), .rst(rst),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .EXTOp(EXTOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .SASrc(SASrc),
    .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel), .IorD(IorD),
    .mem_rdata(mem_rdata), .alu_result(alu_result),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .op(op), .funct(funct), .pc(pc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    PCWrite = 0; IRWrite = 0; EXTOp = 0; SASrc = 0; IorD = 0;
    ALUSrcA = 0; ALUSrcB = 0; PCSource = 0; GPRSel = 0; WDSel = 0;
  endtask

  task automatic drive_data(input logic [31:0] rdata, input logic [31:0] alu,
                            input logic [31:0] rd1, input logic [31:0] rd2);
    mem_rdata = rdata; alu_result = alu; rf_rd1 = rd1; rf_rd2 = rd2;
  endtask

  initial begin
    rst = 1'b1;
    idle_ctrl();
    drive_data(32'd0, 32'd0, 32'd0, 32'd0);
    #12 rst = 1'b0;

    // Load PC = 0x40 and a nonzero IR so reset has something to clear.
    PCWrite = 1; IRWrite = 1; PCSource = 0;
    drive_data(32'hFFFF_FFFF, 32'h40, 32'h55, 32'h66);
    step();
    idle_ctrl();
    check("pre_rst_pc", pc, 32'h40);
    check("pre_rst_op", {26'd0, op}, 32'h3F);

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1;
    check("rst_pc", pc, 32'h3000);
    check("rst_op", {26'd0, op}, 32'h0);
    check("rst_funct", {26'd0, funct}, 32'h0);
    check("rst_B", mem_wdata, 32'h0);
    WDSel = 0; #1 check("rst_aluout", rf_wd, 32'h0);
    WDSel = 1; #1 check("rst_mdr", rf_wd, 32'h0);
    ALUSrcA = 1; #1 check("rst_A", alu_a, 32'h0);
    idle_ctrl();
    step();
    #3 rst = 1'b0;

    // IF: fetch addi at 0x3000.
    PCWrite = 1; IRWrite = 1; PCSource = 0; IorD = 0; ALUSrcA = 0; ALUSrcB = 1;
    drive_data(32'h2008_0005, 32'h3004, 32'd0, 32'd0);
    #1;
    check("if_mem_addr", mem_addr, 32'h3000);
    check("if_alu_a", alu_a, 32'h3000);
    check("if_alu_b", alu_b, 32'd4);
    step();
    idle_ctrl();
    check("if_pc", pc, 32'h3004);
    check("if_op", {26'd0, op}, 32'h08);
    check("if_funct", {26'd0, funct}, 32'h05);
    check("if_ra1", {27'd0, rf_ra1}, 32'd0);
    check("if_ra2", {27'd0, rf_ra2}, 32'd8);
    GPRSel = 1; #1 check("if_wa_rt", {27'd0, rf_wa}, 32'd8);
    GPRSel = 0; #1 check("if_wa_rd", {27'd0, rf_wa}, 32'd0);

    // Branch offset: load IR with imm16 = 0xFFFF.
    IRWrite = 1; mem_rdata = 32'h1000_FFFF;
    step();
    idle_ctrl();
    EXTOp = 1; ALUSrcB = 3; #1 check("imm_sext_sh2", alu_b, 32'hFFFF_FFFC);
    EXTOp = 0; ALUSrcB = 2; #1 check("imm_zext", alu_b, 32'h0000_FFFF);
    EXTOp = 1; ALUSrcB = 2; #1 check("imm_sext", alu_b, 32'hFFFF_FFFF);
    EXTOp = 0; ALUSrcB = 3; #1 check("imm_zext_sh2", alu_b, 32'h0003_FFFC);
    check("beq_pc_hold", pc, 32'h3004);

    // jal: IR = 0x0C000C10, PC = 0x3004.
    idle_ctrl();
    IRWrite = 1; mem_rdata = 32'h0C00_0C10;
    step();
    idle_ctrl();
    PCSource = 2; GPRSel = 2; WDSel = 2; PCWrite = 1;
    #1;
    check("jal_wa", {27'd0, rf_wa}, 32'd31);
    check("jal_wd", rf_wd, 32'h3004);
    GPRSel = 3; #1 check("wa_zero", {27'd0, rf_wa}, 32'd0);
    step();
    idle_ctrl();
    check("jal_pc", pc, 32'h0000_3040);

    // jr: A holds an older rs value while rf_rd1 already carries the target.
    rf_rd1 = 32'h1111;
    step();
    rf_rd1 = 32'h3100; PCSource = 3; PCWrite = 1; ALUSrcA = 1;
    #1 check("jr_A_old", alu_a, 32'h1111);
    step();
    PCWrite = 0;
    check("jr_pc", pc, 32'h3100);
    check("jr_A_new", alu_a, 32'h3100);
    idle_ctrl();

    // lw: ALUOut = 0x10 addresses memory, MDR returns the word a cycle later.
    alu_result = 32'h10;
    step();
    IorD = 1; mem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1 check("lw_mem_addr", mem_addr, 32'h10);
    step();
    mem_rdata = 32'h0; WDSel = 1;
    #1 check("lw_wd_mdr", rf_wd, exp_q.pop_front());
    WDSel = 0; #1 check("wd_aluout", rf_wd, 32'h10);
    WDSel = 3; #1 check("wd_zero", rf_wd, 32'h0);
    idle_ctrl();

    // Shift amount sources, B path, ALUSrcA = 2/3.
    rf_rd1 = 32'h23; rf_rd2 = 32'hCAFE;
    step();
    SASrc = 1; #1 check("sllv_shamt", {27'd0, alu_shamt}, 32'd3);
    SASrc = 0; #1 check("sll_shamt", {27'd0, alu_shamt}, 32'd16);
    check("mem_wdata_B", mem_wdata, 32'hCAFE);
    ALUSrcA = 2; #1 check("alu_a_B", alu_a, 32'hCAFE);
    ALUSrcA = 3; #1 check("alu_a_zero", alu_a, 32'h0);
    ALUSrcB = 0; #1 check("alu_b_B", alu_b, 32'hCAFE);
    idle_ctrl();

    // PC from ALUOut at the top of memory, then a jump keeps PC[31:28].
    alu_result = 32'hFFFF_FFFC;
    step();
    alu_result = 32'h0; PCWrite = 1; PCSource = 1;
    step();
    check("pc_aluout", pc, 32'hFFFF_FFFC);
    PCSource = 2;
    step();
    idle_ctrl();
    check("jump_region", pc, 32'hF000_3040);
    // External ALU wraps PC+4 to zero; PCSource = 0 loads it.
    alu_result = 32'h0; PCWrite = 1; PCSource = 0;
    step();
    idle_ctrl();
    check("pc_wrap", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
